instr_fetch: RTL and testbench

Instruction fetch stage for the MIPS core; sits between the byte-wide instruction memory and the decode/register-file stage inside mips_top. Reads four consecutive bytes per instruction from the synchronous byte memory and assembles them big-endian, so the byte at the lowest address is bits 31:24. Offers the word to decode with a valid/ready handshake and accepts PC redirects from downstream.

---
 rtl/instr_fetch_if.sv | 15 +
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-to-decode handshake bundle.
//   out_valid  fetch -> decode  out_instr/out_pc hold a fetched instruction
//   out_ready  decode -> fetch  decode accepts the instruction this cycle
//   out_instr  fetch -> decode  assembled big-endian instruction word
//   out_pc     fetch -> decode  byte address of out_instr
// master: the fetch stage; slave: the decode stage.
interface instr_fetch_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (output out_valid, output out_instr, output out_pc, input out_ready);
    modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction fetch stage. Reads four consecutive bytes
// from a synchronous byte-wide memory (one-cycle read latency), assembles
// them big-endian (lowest address -> bits 31:24) and offers the word to
// decode over a valid/ready handshake. Downstream may redirect the PC.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   imem_addr       byte address to instruction memory (ADDR_W bits)
//   imem_re         read enable; data returns on imem_rdata next cycle
//   imem_rdata      byte returned for the previous cycle's address
//   out_if          instr_fetch_if.master handshake to decode
//   redirect_valid  PC change request (beats every event except reset)
//   redirect_pc     new PC; bits 1:0 forced to zero
//
// Optional feature macro: PREDECODE_JUMP_EN -- when defined, a 'j'
// instruction is resolved inside the fetch stage and never delivered.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_re,
    input  logic [7:0]        imem_rdata,
    instr_fetch_if.master     out_if,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LAST  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;

    logic [31:0] assembled;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    assign assembled       = {word_q[23:0], imem_rdata};
    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = redirect_pc & ~32'h3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;

        unique case (state_q)
            FETCH: begin
                // Count 0 has no read of this fetch in flight (the previous
                // cycle was LAST, VALID or an aborted read), so skip the shift.
                if (byte_cnt_q != 2'd0) begin
                    word_d = assembled;
                end
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                word_d  = assembled;
                state_d = VALID;
`ifdef PREDECODE_JUMP_EN
                if (assembled[31:26] == 6'b000010) begin
                    pc_d       = {pc_plus4[31:28], assembled[25:0], 2'b00};
                    byte_cnt_d = '0;
                    state_d    = FETCH;
                end
`endif
            end
            VALID: begin
                if (out_if.out_ready) begin
                    pc_d       = pc_plus4;
                    byte_cnt_d = '0;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (redirect_valid) begin
            pc_d       = redirect_target;
            byte_cnt_d = '0;
            word_d     = '0;
            state_d    = FETCH;
        end
    end

    // Reads are masked while reset is held so the read enable shows its
    // reset value during the reset cycle itself.
    assign imem_re          = (state_q == FETCH) && !rst;
    assign imem_addr        = pc_q[ADDR_W-1:0] + ADDR_W'(byte_cnt_q);
    assign out_if.out_valid = (state_q == VALID);
    assign out_if.out_instr = word_q;
    assign out_if.out_pc    = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a byte memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_re;
    logic [7:0]  imem_rdata = 8'h00;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_re        (imem_re),
        .imem_rdata     (imem_rdata),
        .out_if         (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_re) imem_rdata <= mem[imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int exp_n, input logic [31:0] exp_pc,
                              input logic [31:0] exp_instr);
        int n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, exp_n);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_pc"}, bus.out_pc, exp_pc);
        check({tag, "_instr"}, bus.out_instr, exp_instr);
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] base;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[0], mem[1], mem[2], mem[3]}          = 32'h2000_0001;
        {mem[4], mem[5], mem[6], mem[7]}          = 32'h0800_0000;
        {mem[16], mem[17], mem[18], mem[19]}      = 32'h1122_3344;
        {mem[32], mem[33], mem[34], mem[35]}      = 32'hAABB_CCDD;
        {mem[252], mem[253], mem[254], mem[255]}  = 32'h0102_0304;

        rst = 1'b1;
        bus.out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_re", {31'd0, imem_re}, 32'd0);
        check("rst_addr", {24'd0, imem_addr}, 32'h0);

        // First fetch: addresses 0..3 in cycles 0..3, LAST in cycle 4.
        rst = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("boot_re%0d", c), {31'd0, imem_re}, 32'd1);
            check($sformatf("boot_addr%0d", c), {24'd0, imem_addr}, c);
            tick();
        end
        check("last_re", {31'd0, imem_re}, 32'd0);
        check("last_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_valid("first", 1, 32'h0, 32'h2000_0001);

        // Stall: outputs hold, no reads.
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall_valid%0d", c), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("stall_instr%0d", c), bus.out_instr, 32'h2000_0001);
            check($sformatf("stall_pc%0d", c), bus.out_pc, 32'h0);
            check($sformatf("stall_re%0d", c), {31'd0, imem_re}, 32'd0);
        end
        accept();
        check("next_addr", {24'd0, imem_addr}, 32'h4);
        check("next_re", {31'd0, imem_re}, 32'd1);
        check("next_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef PREDECODE_JUMP_EN
        wait_valid("jump", 10, 32'h0, 32'h2000_0001);
        base = 32'h4;
`else
        wait_valid("jump", 5, 32'h4, 32'h0800_0000);
        base = 32'h8;
`endif
        accept();

        // Redirect to 0x13 while byte_cnt=2.
        tick();
        tick();
        check("mid_addr", {24'd0, imem_addr}, base + 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h13;
        tick();
        redirect_valid = 1'b0;
        check("redir_addr", {24'd0, imem_addr}, 32'h10);
        check("redir_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_valid("redir", 5, 32'h10, 32'h1122_3344);

        // Redirect beats a same-cycle handshake.
        bus.out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        tick();
        bus.out_ready = 1'b0;
        redirect_valid = 1'b0;
        check("prio_addr", {24'd0, imem_addr}, 32'h20);
        check("prio_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_valid("prio", 5, 32'h20, 32'hAABB_CCDD);

        // Reset during byte_cnt=1.
        accept();
        tick();
        check("pre_rst_addr", {24'd0, imem_addr}, 32'h25);
        rst = 1'b1;
        tick();
        check("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_instr", bus.out_instr, 32'h0);
        check("mrst_pc", bus.out_pc, 32'h0);
        check("mrst_re", {31'd0, imem_re}, 32'd0);
        check("mrst_addr", {24'd0, imem_addr}, 32'h0);
        rst = 1'b0;
        #1;
        check("mrst_restart_re", {31'd0, imem_re}, 32'd1);
        wait_valid("mrst", 5, 32'h0, 32'h2000_0001);

        // PC wrap: 0xFFFFFFFC + 4 -> 0; redirect low bits dropped.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr", {24'd0, imem_addr}, 32'hFC);
        wait_valid("top", 5, 32'hFFFF_FFFC, 32'h0102_0304);
        accept();
        check("wrap_next_addr", {24'd0, imem_addr}, 32'h0);
        wait_valid("wrap", 5, 32'h0, 32'h2000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
